load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Responder for the ALU's memory-operation output. It consumes the registered load/store request (address, store data, funct3 opType, rdAddr, read/write strobes).
- Drives a single-outstanding data-memory request/acknowledge bus.
- For loads, returns the aligned and extended result as a register-writeback beat in the ALU regOp format (addr, data, dv).
- Sits between the ALU stage and the data memory. Its busy output stalls the upstream pipeline.

Parameters:
- cDataWidth, 32, data/register width; byte lanes = cDataWidth/8 (fixed 4 in this revision).
- cAddrWidth, 32, byte address width.
- cRegAddrWidth, 5, register-file address width.

Ports:
- iClk  in  1  core clock
- iRst  in  1  synchronous active-high reset
- iMemRead  in  1  load request strobe (ALU memOp.read)
- iMemWrite  in  1  store request strobe (ALU memOp.write)
- iAddr  in  cAddrWidth  byte address (rs1+imm)
- iData  in  cDataWidth  store data (rs2)
- iOpType  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- iRdAddr  in  cRegAddrWidth  load destination register
- oBusy  out  1  high while a request is in flight; upstream holds its request
- oMemReq  out  1  memory request valid
- oMemWe  out  1  1 = write, 0 = read
- oMemAddr  out  cAddrWidth  word-aligned address (iAddr with [1:0] = 0)
- oMemWData  out  cDataWidth  lane-replicated store data
- oMemBe  out  4  byte enables
- iMemAck  in  1  memory completion; valid only while oMemReq = 1
- iMemRData  in  cDataWidth  read word, valid with iMemAck
- oRegDv  out  1  writeback valid, one-cycle pulse
- oRegAddr  out  cRegAddrWidth  writeback register
- oRegData  out  cDataWidth  writeback data
- oFault  out  1  one-cycle pulse: misaligned address or illegal opType

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- The clock is iClk. Reset is synchronous, active-high, on iRst.
- All outputs are registered.
- Reset mid-operation: return to IDLE at that edge and drop oMemReq. Any subsequent iMemAck is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample the inputs at each edge.
  - iMemWrite = 1 takes priority over iMemRead when both are high.
  - Fault conditions:
    - H/HU with addr[0] = 1.
    - W with addr[1:0] != 0.
    - Load opType 011, 110 or 111.
    - Store opType other than 000/001/010.
  - On a fault: oFault = 1 for one cycle, no memory request, no writeback, stay in IDLE.
  - Otherwise: latch the request, set oMemReq = 1 and oBusy = 1, go to ACCESS.
- ACCESS:
  - oMemReq, oMemWe, oMemAddr, oMemWData and oMemBe stay stable until the edge at which iMemAck = 1.
  - Store ack: drop oMemReq and oBusy, go to IDLE.
  - Load ack: capture and extract the data, drop oMemReq, go to RESP.
  - Ack may arrive on the first ACCESS cycle. Wait is unbounded.
- RESP:
  - oRegDv = 1 for exactly one cycle, with oRegAddr and oRegData.
  - oBusy stays 1 in this cycle; go to IDLE.
  - rdAddr = 0: the memory access still occurs, but oRegDv stays 0.
- Store lanes (lane = addr[1:0]):
  - SB: Be = 0001 << lane; WData = byte replicated x4.
  - SH: Be = 0011 << {addr[1],0}; WData = half replicated x2.
  - SW: Be = 1111; WData = data.
- Load extraction:
  - LB/LBU select byte lane addr[1:0].
  - LH/LHU select half addr[1].
  - B and H sign-extend; BU and HU zero-extend; LW passes the full word.
- Latency:
  - The accept edge is T. oMemReq is high from T+1.
  - For an ack sampled at edge A, oRegDv is high in the cycle after A.
  - The next request can be accepted at the edge where the FSM returns to IDLE, i.e. one edge after the RESP cycle.
- Strobes arriving while oBusy = 1 are ignored; upstream must hold them.

Test Plan:
- SW addr 0x0000_1004, data 0xDEADBEEF, ack after 3 cycles -> oMemAddr 0x1004, Be 1111, WData 0xDEADBEEF, oMemWe = 1; no oRegDv; oBusy low after ack.
- SB addr 0x0000_2003, data 0x0000_00A5 -> Be 1000, WData 0xA5A5A5A5.
- LB addr 0x0000_3002, rd = 7, rdata 0x1280_3456 with same-cycle ack -> oRegDv one cycle later, oRegAddr 7, oRegData 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- LH addr 0x0000_4001 -> oFault pulse, oMemReq never asserts, oBusy stays 0. LW addr 0x...2 -> same result. Load opType 111 -> same result.
- LW rd = 0 -> memory read performed, oRegDv stays 0, oBusy returns to 0.
- iRst asserted during ACCESS, then a late iMemAck -> next cycle all outputs are 0 and no oRegDv ever appears. iMemRead and iMemWrite both high -> store is performed.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one ALU memory operation into a single-outstanding
// data-memory request and returns aligned, extended load data as a writeback beat.
module load_store_unit #(
  parameter int cDataWidth    = 32,
  parameter int cAddrWidth    = 32,
  parameter int cRegAddrWidth = 5
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iMemRead,
  input  logic                     iMemWrite,
  input  logic [cAddrWidth-1:0]    iAddr,
  input  logic [cDataWidth-1:0]    iData,
  input  logic [2:0]               iOpType,
  input  logic [cRegAddrWidth-1:0] iRdAddr,
  output logic                     oBusy,
  output logic                     oMemReq,
  output logic                     oMemWe,
  output logic [cAddrWidth-1:0]    oMemAddr,
  output logic [cDataWidth-1:0]    oMemWData,
  output logic [3:0]               oMemBe,
  input  logic                     iMemAck,
  input  logic [cDataWidth-1:0]    iMemRData,
  output logic                     oRegDv,
  output logic [cRegAddrWidth-1:0] oRegAddr,
  output logic [cDataWidth-1:0]    oRegData,
  output logic                     oFault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t                   state_q;
  logic                     is_store_q;
  logic [2:0]               op_q;
  logic [1:0]               lane_q;
  logic [cRegAddrWidth-1:0] rd_q;

  logic                     busy_q;
  logic                     mem_req_q;
  logic                     mem_we_q;
  logic [cAddrWidth-1:0]    mem_addr_q;
  logic [cDataWidth-1:0]    mem_wdata_q;
  logic [3:0]               mem_be_q;
  logic                     reg_dv_q;
  logic [cRegAddrWidth-1:0] reg_addr_q;
  logic [cDataWidth-1:0]    reg_data_q;
  logic                     fault_q;

  logic                     req_d;
  logic                     fault_d;
  logic [3:0]               be_d;
  logic [cDataWidth-1:0]    wdata_d;
  logic [7:0]               byte_d;
  logic [15:0]              half_d;
  logic [cDataWidth-1:0]    load_d;

  assign req_d = iMemRead | iMemWrite;

  // Fault check: a store wins over a load when both strobes are high.
  always_comb begin
    fault_d = 1'b0;
    if (iMemWrite) begin
      if (iOpType != OP_B && iOpType != OP_H && iOpType != OP_W)
        fault_d = 1'b1;
    end else begin
      if (iOpType == 3'b011 || iOpType == 3'b110 || iOpType == 3'b111)
        fault_d = 1'b1;
    end
    if ((iOpType == OP_H || iOpType == OP_HU) && iAddr[0])
      fault_d = 1'b1;
    if (iOpType == OP_W && iAddr[1:0] != 2'b00)
      fault_d = 1'b1;
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = iData;
    case (iOpType)
      OP_B: begin
        be_d    = 4'b0001 << iAddr[1:0];
        wdata_d = {4{iData[7:0]}};
      end
      OP_H: begin
        be_d    = iAddr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{iData[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = iData;
      end
    endcase
  end

  // Load extraction from the returned word using the latched lane and opType.
  always_comb begin
    byte_d = iMemRData[7:0];
    case (lane_q)
      2'd0:    byte_d = iMemRData[7:0];
      2'd1:    byte_d = iMemRData[15:8];
      2'd2:    byte_d = iMemRData[23:16];
      default: byte_d = iMemRData[31:24];
    endcase
    half_d = lane_q[1] ? iMemRData[31:16] : iMemRData[15:0];
    case (op_q)
      OP_B:    load_d = {{24{byte_d[7]}}, byte_d};
      OP_H:    load_d = {{16{half_d[15]}}, half_d};
      OP_BU:   load_d = {24'd0, byte_d};
      OP_HU:   load_d = {16'd0, half_d};
      default: load_d = iMemRData;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'd0;
      reg_dv_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      fault_q  <= 1'b0;
      reg_dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d) begin
            if (fault_d) begin
              fault_q <= 1'b1;
            end else begin
              is_store_q  <= iMemWrite;
              op_q        <= iOpType;
              lane_q      <= iAddr[1:0];
              rd_q        <= iRdAddr;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= iMemWrite;
              mem_addr_q  <= {iAddr[cAddrWidth-1:2], 2'b00};
              mem_wdata_q <= iMemWrite ? wdata_d : '0;
              mem_be_q    <= iMemWrite ? be_d : 4'b1111;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (iMemAck) begin
            mem_req_q <= 1'b0;
            if (is_store_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              // rd = 0 still completes the read but produces no writeback.
              reg_dv_q   <= (rd_q != '0);
              reg_addr_q <= rd_q;
              reg_data_q <= load_d;
              state_q    <= RESP;
            end
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign oBusy     = busy_q;
  assign oMemReq   = mem_req_q;
  assign oMemWe    = mem_we_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oMemBe    = mem_be_q;
  assign oRegDv    = reg_dv_q;
  assign oRegAddr  = reg_addr_q;
  assign oRegData  = reg_data_q;
  assign oFault    = fault_q;

endmodule
